// File: rtl/sum_acc_pkg.sv
// sum_accumulator shared types and constants.
// FSM state encoding and counter limit helper.
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 8;

    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Input beat stream and held result handshake.
// slave is the accumulator side, master the producer/consumer side.
interface sum_accumulator_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_count,
        output out_ovf
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_count,
        input  out_ovf
    );

endinterface

// File: rtl/sum_accumulator_add32_co.sv
// Combinational WIDTH-bit adder with carry-in and carry-out.
// Plain ripple form; synthesis picks the carry structure.
module add32_co #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];

endmodule

// File: rtl/sum_accumulator.sv
// Packet accumulator: sums a beat stream and holds total,
// saturating beat count and sticky carry until consumed.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    sum_accumulator_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             accept;
    logic [WIDTH-1:0] add_sum;
    logic             add_co;

    add32_co #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (acc_q),
        .b    (bus.in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_co)
    );

    assign bus.in_ready  = (state_q != HOLD);
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                // first beat loads directly, bypassing the adder
                if (accept) begin
                    acc_d   = bus.in_data;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = bus.in_last ? HOLD : ACC;
                end
            end
            (state_q == ACC): begin
                if (accept) begin
                    acc_d   = add_sum;
                    ovf_d   = ovf_q | add_co;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d = bus.in_last ? HOLD : ACC;
                end
            end
            (state_q == HOLD): begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator (CNT_W=8 and CNT_W=2 copies).
// Directed scenarios plus randomized packets against a packet-level model.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    int compared = 0;
    int mismatched = 0;

    sum_accumulator_if #(.WIDTH(32), .CNT_W(8)) b8 ();
    sum_accumulator_if #(.WIDTH(32), .CNT_W(2)) b2 ();

    assign b8.in_valid  = in_valid;
    assign b8.in_data   = in_data;
    assign b8.in_last   = in_last;
    assign b8.out_ready = out_ready;
    assign b2.in_valid  = in_valid;
    assign b2.in_data   = in_data;
    assign b2.in_last   = in_last;
    assign b2.out_ready = out_ready;

    sum_accumulator #(.WIDTH(32), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8.slave)
    );

    sum_accumulator #(.WIDTH(32), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2.slave)
    );

    always #5 clk = ~clk;

    // Present one beat from a negedge; it is taken at the following posedge.
    task automatic send_beat(input logic [31:0] d, input bit last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!b8.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            compared++;
            mismatched++;
            $display("FAIL beat_timeout: in_ready stuck at %0b, required 1", b8.in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (b8.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_out_valid: got %0b, required 0", b8.out_valid);
        end
        compared++;
        if (b8.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %0b, required 1", b8.in_ready);
        end
        compared++;
        if (b8.out_count !== 8'd0 || b8.out_sum !== 32'd0 || b8.out_ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_regs: sum %0h cnt %0d ovf %0b, required 0 0 0",
                     b8.out_sum, b8.out_count, b8.out_ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        out_ready = 1'b1;
        send_beat(32'd5, 1'b0);
        send_beat(32'd7, 1'b0);
        compared++;
        if (b8.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL nom_early_valid: got %0b, required 0", b8.out_valid);
        end
        send_beat(32'd11, 1'b1);
        compared++;
        if (b8.out_valid !== 1'b1 || b8.out_sum !== 32'd23 ||
            b8.out_count !== 8'd3 || b8.out_ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL nom_result: v %0b sum %0d cnt %0d ovf %0b, required 1 23 3 0",
                     b8.out_valid, b8.out_sum, b8.out_count, b8.out_ovf);
        end
        compared++;
        if (b8.in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL nom_hold_ready: got %0b, required 0", b8.in_ready);
        end
        @(negedge clk);
        compared++;
        if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL nom_idle: v %0b rdy %0b, required 0 1", b8.out_valid, b8.in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        send_beat(32'hFFFF_FFF0, 1'b0);
        send_beat(32'h0000_0020, 1'b1);
        compared++;
        if (b8.out_valid !== 1'b1 || b8.out_sum !== 32'h10 ||
            b8.out_count !== 8'd2 || b8.out_ovf !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_result: v %0b sum %0h cnt %0d ovf %0b, required 1 10 2 1",
                     b8.out_valid, b8.out_sum, b8.out_count, b8.out_ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        send_beat(32'd1, 1'b1);
        compared++;
        if (b8.out_valid !== 1'b1 || b8.out_sum !== 32'd1 ||
            b8.out_count !== 8'd1 || b8.out_ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_clear: v %0b sum %0h cnt %0d ovf %0b, required 1 1 1 0",
                     b8.out_valid, b8.out_sum, b8.out_count, b8.out_ovf);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            compared++;
            if (b8.in_ready !== 1'b0 || b8.out_valid !== 1'b1 ||
                b8.out_sum !== 32'd3 || b8.out_count !== 8'd2) begin
                mismatched++;
                $display("FAIL bp_stall[%0d]: rdy %0b v %0b sum %0d cnt %0d, required 0 1 3 2",
                         i, b8.in_ready, b8.out_valid, b8.out_sum, b8.out_count);
            end
            // a beat offered while held must not be absorbed
            in_valid = 1'b1;
            in_data  = 32'd100;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_release: v %0b rdy %0b, required 0 1", b8.out_valid, b8.in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_beat(32'd1, i == 4);
        end
        compared++;
        if (b2.out_valid !== 1'b1 || b2.out_count !== 2'd3 || b2.out_sum !== 32'd5) begin
            mismatched++;
            $display("FAIL sat_cnt2: v %0b cnt %0d sum %0d, required 1 3 5",
                     b2.out_valid, b2.out_count, b2.out_sum);
        end
        compared++;
        if (b8.out_count !== 8'd5) begin
            mismatched++;
            $display("FAIL sat_cnt8: got %0d, required 5", b8.out_count);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_beat(32'd100, 1'b0);
        send_beat(32'd200, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1 || b8.out_count !== 8'd0) begin
            mismatched++;
            $display("FAIL rstmid_async: v %0b rdy %0b cnt %0d, required 0 1 0",
                     b8.out_valid, b8.in_ready, b8.out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(32'd9, 1'b1);
        compared++;
        if (b8.out_valid !== 1'b1 || b8.out_sum !== 32'd9 || b8.out_count !== 8'd1) begin
            mismatched++;
            $display("FAIL rstmid_next: v %0b sum %0d cnt %0d, required 1 9 1",
                     b8.out_valid, b8.out_sum, b8.out_count);
        end
        // reset while a result is held must drop it with no clock edge
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rsthold_async: v %0b rdy %0b, required 0 1", b8.out_valid, b8.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_gap();
        out_ready = 1'b1;
        in_last = 1'b1;
        @(negedge clk);
        in_last = 1'b0;
        send_beat(32'd4, 1'b0);
        in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (b8.out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL gap_last_ignored[%0d]: v %0b, required 0", i, b8.out_valid);
            end
        end
        in_last = 1'b0;
        send_beat(32'd6, 1'b1);
        compared++;
        if (b8.out_valid !== 1'b1 || b8.out_sum !== 32'd10 || b8.out_count !== 8'd2) begin
            mismatched++;
            $display("FAIL gap_result: v %0b sum %0d cnt %0d, required 1 10 2",
                     b8.out_valid, b8.out_sum, b8.out_count);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        longint unsigned total;
        logic [31:0]     words[$];
        logic [31:0]     exp_sum;
        bit              exp_ovf;
        int              n;
        int              exp_c2;
        out_ready = 1'b0;
        for (int p = 0; p < 25; p++) begin
            n = $urandom_range(1, 7);
            words.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    words.push_back(32'hC000_0000 | 32'($urandom));
                else
                    words.push_back(32'($urandom_range(0, 5000)));
            end
            total = 0;
            foreach (words[i]) total += longint'(words[i]);
            exp_sum = total[31:0];
            exp_ovf = (total > 64'h0000_0000_FFFF_FFFF);
            exp_c2  = (n > 3) ? 3 : n;
            foreach (words[i]) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_last = 1'($urandom);
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                    in_last = 1'b0;
                end
                send_beat(words[i], i == n - 1);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            compared++;
            if (b8.out_valid !== 1'b1 || b8.out_sum !== exp_sum ||
                b8.out_count !== 8'(n) || b8.out_ovf !== exp_ovf) begin
                mismatched++;
                $display("FAIL rand_pkt%0d: v %0b sum %0h cnt %0d ovf %0b, required 1 %0h %0d %0b",
                         p, b8.out_valid, b8.out_sum, b8.out_count, b8.out_ovf,
                         exp_sum, n, exp_ovf);
            end
            compared++;
            if (b2.out_count !== 2'(exp_c2) || b2.out_sum !== exp_sum) begin
                mismatched++;
                $display("FAIL rand_sat%0d: cnt %0d sum %0h, required %0d %0h",
                         p, b2.out_count, b2.out_sum, exp_c2, exp_sum);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overflow();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_idle_gap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Streaming accumulation stage that sits downstream of the 32-bit adder datapath.
- Accepts a packet of 32-bit words over a valid/ready handshake and sums them through an internal adder with carry-out.
- Presents the packet total, beat count and sticky overflow flag on a held output handshake.
- Provides the registered, flow-controlled wrapper that a bare combinational adder lacks.

Parameters:
- WIDTH, 32, data and sum width in bits.
- CNT_W, 8, width of the beat counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last are valid this cycle.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  WIDTH  operand word.
- in_last  input  1  final beat of the packet.
- out_valid  output  1  result is available and held.
- out_ready  input  1  consumer takes the result.
- out_sum  output  WIDTH  packet sum modulo 2^WIDTH.
- out_count  output  CNT_W  number of beats accepted, saturating.
- out_ovf  output  1  sticky unsigned carry-out seen during the packet.

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous and active-low.
- Reset state: state=IDLE, acc=0, count=0, ovf=0, out_valid=0, in_ready=1 one delta after reset assert. Outputs go to reset values immediately, independent of clk.
- Beat acceptance: a beat is accepted on a rising edge where in_valid && in_ready. in_ready is combinational: in_ready = (state != HOLD).
- State IDLE, on accept:
  - acc <= in_data, count <= 1, ovf <= 0.
  - Next state is HOLD if in_last, else ACC.
- State ACC, on accept:
  - {carry, acc} <= acc + in_data.
  - ovf <= ovf | carry.
  - count <= count+1, saturating at all-ones; no wrap.
  - Next state is HOLD if in_last, else stay ACC.
- State HOLD:
  - out_valid=1. out_sum/out_count/out_ovf are driven directly from acc/count/ovf and must not change while out_valid=1.
  - On an out_ready edge: go to IDLE. acc/count/ovf retain their values, but outputs are don't-care once out_valid=0.
- No accept: when no beat is accepted, all registers hold.
- Latency: the last beat is accepted at edge k, and out_valid=1 from just after edge k. A single-beat packet is legal: sum = that word, count = 1, ovf = 0.
- Throughput:
  - One beat per cycle while in ACC.
  - At least one bubble between packets, because in_ready=0 in HOLD. The next packet can be accepted no earlier than the edge after the out_ready handshake.
- Consumer backpressure: out_ready held low stalls indefinitely. in_ready stays 0 for the whole time.
- in_last handling: only meaningful while in_valid=1. in_last with in_valid=0 is ignored.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - carry is the adder's carry-out at bit WIDTH-1.
  - Signed overflow is not reported.
- Reset mid-packet: the partial sum is discarded and the block returns to IDLE. No output handshake is produced.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Package sum_acc_pkg:
  - state enum {IDLE, ACC, HOLD} as a 2-bit typedef.
  - constants WIDTH_DEF=32, CNT_W_DEF=8.
  - CNT_MAX localparam function.
- One sub-module, add32_co:
  - combinational WIDTH-bit adder, ports a, b, cin, sum, cout.
  - cin is tied 0 here.
  - Implementation may be ripple or carry-select. It is instantiated once, with a=acc and b=in_data.
  - In IDLE the register load bypasses the adder.

Test Plan:
- Nominal 3-beat packet: 5, 7, 11 with last on beat 3, out_ready=1 → out_valid one edge after beat 3, out_sum=23, out_count=3, out_ovf=0, then IDLE with in_ready=1.
- Overflow: 0xFFFF_FFF0, 0x20 (last) → out_sum=0x0000_0010, out_ovf=1. A following packet 1 (last) gives out_ovf=0.
- Backpressure: packet 1, 2 (last) with out_ready=0 for 10 cycles → in_ready=0 and out_sum=3 stable for all 10 cycles. out_ready=1 completes the handshake and in_ready=1 next cycle.
- Count saturation with CNT_W=2: 5 beats of value 1 → out_count=3, out_sum=5.
- Reset mid-packet: 2 beats accepted, then rst_n low asynchronously between edges → out_valid=0 and in_ready=1 immediately. The next packet 9 (last) gives out_sum=9, out_count=1.
- Single-beat and idle-gap stimulus: in_valid toggling with gaps, packet 4, gap, 6 (last) → out_sum=10, out_count=2. in_last asserted with in_valid=0 is ignored.
